mac_vec_engine: RTL and testbench

Parametrised multi-lane multiply-accumulate engine. It performs LANES parallel dot products of length cfg_len over streamed operand vectors. It supports signed and unsigned modes, saturating accumulation with sticky overflow flags, a valid/ready input stream and a valid/ready result handshake. It is the successor to the single-lane enable/clear MAC and sits between the operand-fetch stream and the result writeback path.

---
 rtl/mac_vec_engine.sv | 129 ++++++++++++
 tb/tb_mac_vec_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec_engine.sv
// LANES-wide dot-product engine: 2-stage multiply/saturating-accumulate, valid/ready in and out.
// Result valid two edges after the last accepted beat; stalls on in_valid=0 and holds result while out_ready=0.
module mac_vec_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cfg_signed,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   a_in,
  input  logic [LANES*DATA_WIDTH-1:0]   b_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*ACC_WIDTH-1:0]    acc_out,
  output logic [LANES-1:0]              sat_flag
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int EXT = ACC_WIDTH + 1 - PW;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, cnt_q;
  logic                 sgn_q;
  logic                 prod_vld_q;
  logic                 start_fire, accept, last_beat;

  assign start_fire = (state_q == S_IDLE) && start;
  assign accept     = (state_q == S_RUN) && in_valid;
  assign last_beat  = accept && (cnt_q == len_q - LEN_ONE);

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_RUN);
  assign out_valid = (state_q == S_OUT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cfg_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (last_beat) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prod_vld_q <= accept;
      if (start_fire) begin
        len_q <= cfg_len;
        sgn_q <= cfg_signed;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_ONE;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] a, b;
    logic [PW-1:0]         ax, bx, prod_d, prod_q;
    logic [ACC_WIDTH-1:0]  acc_q, acc_nxt;
    logic [ACC_WIDTH:0]    acc_ext, prod_ext, sum;
    logic                  sat_q, sat_hit;

    assign a = a_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign b = b_in[g*DATA_WIDTH +: DATA_WIDTH];
    // Low PW bits of the product of extended operands give the exact signed or unsigned product.
    assign ax     = sgn_q ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
    assign bx     = sgn_q ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
    assign prod_d = ax * bx;

    assign acc_ext  = sgn_q ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
    assign prod_ext = sgn_q ? {{EXT{prod_q[PW-1]}}, prod_q} : {{EXT{1'b0}}, prod_q};
    assign sum      = acc_ext + prod_ext;

    always_comb begin
      sat_hit = 1'b0;
      acc_nxt = sum[ACC_WIDTH-1:0];
      if (sgn_q) begin
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
          sat_hit = 1'b1;
          acc_nxt = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else if (sum[ACC_WIDTH]) begin
        sat_hit = 1'b1;
        acc_nxt = '1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        acc_q  <= '0;
        sat_q  <= 1'b0;
      end else begin
        if (accept) prod_q <= prod_d;
        if (start_fire) begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end else if (prod_vld_q) begin
          acc_q <= acc_nxt;
          if (sat_hit) sat_q <= 1'b1;
        end
      end
    end

    assign acc_out[g*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    assign sat_flag[g] = sat_q;
  end

endmodule

// File: tb/tb_mac_vec_engine.sv
// Directed bench: default 24-bit accumulator instance plus a 16-bit one sharing the same stimulus.
module tb_mac_vec_engine;

  logic        clk, rst_n, start, cfg_signed, in_valid, out_ready;
  logic [7:0]  cfg_len;
  logic [31:0] a_in, b_in;
  logic        busy0, in_ready0, out_valid0;
  logic [95:0] acc0;
  logic [3:0]  sat0;
  logic        busy1, in_ready1, out_valid1;
  logic [63:0] acc1;
  logic [3:0]  sat1;

  int checks = 0;
  int failures = 0;

  mac_vec_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
    .busy(busy0), .in_valid(in_valid), .in_ready(in_ready0), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid0), .out_ready(out_ready), .acc_out(acc0), .sat_flag(sat0)
  );

  mac_vec_engine #(.ACC_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
    .busy(busy1), .in_valid(in_valid), .in_ready(in_ready1), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid1), .out_ready(out_ready), .acc_out(acc1), .sat_flag(sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic sgn);
    cfg_len    = len;
    cfg_signed = sgn;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic beats(input int n, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    repeat (n) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!out_valid0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, out_valid0, 1'b1);
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int pat [6];
    pat = '{1, 0, 1, 0, 1, 1};

    rst_n = 1'b0; start = 1'b0; cfg_signed = 1'b0; cfg_len = '0;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("rst_acc",  acc0, 96'd0);
    chk("rst_busy", {busy0, in_ready0, out_valid0, sat0}, 7'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned dot products with default widths, latency check
    start_job(8'd3, 1'b0);
    chk("t1_in_ready", in_ready0, 1'b1);
    beats(3, {8'd1, 8'd0, 8'd255, 8'd2}, {8'd7, 8'd9, 8'd255, 8'd3});
    chk("t1_drain", {busy0, in_ready0, out_valid0}, 3'b100);
    tick();
    chk("t1_ovld", out_valid0, 1'b1);
    chk("t1_acc", acc0, {24'd21, 24'd0, 24'd195075, 24'd18});
    chk("t1_sat", sat0, 4'h0);
    take_out();
    chk("t1_idle", {busy0, out_valid0}, 2'b00);
    chk("t1_keep", acc0, {24'd21, 24'd0, 24'd195075, 24'd18});

    // Signed mode; config changes after start must not matter
    start_job(8'd2, 1'b1);
    cfg_signed = 1'b0;
    cfg_len    = 8'd5;
    beats(2, {8'h00, 8'h00, 8'h80, 8'hFF}, {8'h00, 8'h00, 8'h80, 8'h05});
    wait_out("t2_ovld");
    chk("t2_acc", acc0, {24'd0, 24'd0, 24'h008000, 24'hFFFFF6});
    chk("t2_sat", sat0, 4'h0);
    take_out();

    // Saturation with a 16-bit accumulator
    start_job(8'd2, 1'b0);
    beats(2, {4{8'hFF}}, {4{8'hFF}});
    wait_out("t3u_ovld");
    chk("t3u_acc16", acc1, {4{16'hFFFF}});
    chk("t3u_sat16", sat1, 4'hF);
    chk("t3u_acc24", acc0, {4{24'd130050}});
    chk("t3u_sat24", sat0, 4'h0);
    take_out();

    start_job(8'd3, 1'b1);
    beats(3, {4{8'h80}}, {4{8'h7F}});
    wait_out("t3s_ovld");
    chk("t3s_acc16", acc1, {4{16'h8000}});
    chk("t3s_sat16", sat1, 4'hF);
    chk("t3s_acc24", acc0, {4{24'hFF4180}});
    take_out();

    // Accumulation continues from the clamped value
    start_job(8'd4, 1'b1);
    beats(3, {4{8'h80}}, {4{8'h7F}});
    beats(1, {4{8'h7F}}, {4{8'h7F}});
    wait_out("t3c_ovld");
    chk("t3c_acc16", acc1, {4{16'hBF01}});
    chk("t3c_sat16", sat1, 4'hF);
    chk("t3c_acc24", acc0, {4{24'hFF8081}});
    take_out();

    // Input stalls and output backpressure
    start_job(8'd4, 1'b0);
    v = 8'd1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (pat[i] == 1);
      a_in     = (pat[i] == 1) ? {4{v}} : {4{8'd100}};
      b_in     = {8'd4, 8'd3, 8'd2, 8'd1};
      tick();
      if (pat[i] == 1) v = v + 8'd1;
      if (i == 1) chk("t4_rdy_stall", in_ready0, 1'b1);
    end
    in_valid = 1'b0;
    chk("t4_drain", {in_ready0, out_valid0}, 2'b00);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_vld", out_valid0, 1'b1);
      chk("t4_hold_acc", acc0, {24'd40, 24'd30, 24'd20, 24'd10});
      tick();
    end
    chk("t4_sat16", sat1, 4'h0);
    take_out();
    chk("t4_idle", busy0, 1'b0);

    // Zero-length job and start while a result is pending
    start_job(8'd0, 1'b0);
    chk("t5_drain", {busy0, in_ready0, out_valid0}, 3'b100);
    tick();
    chk("t5_out", {in_ready0, out_valid0}, 2'b01);
    chk("t5_acc", acc0, 96'd0);
    start_job(8'd3, 1'b0);
    chk("t5_ign_vld", out_valid0, 1'b1);
    chk("t5_ign_acc", acc0, 96'd0);
    take_out();
    tick();
    chk("t5_idle", busy0, 1'b0);

    // Maximum length: counter must not wrap
    start_job(8'd255, 1'b0);
    beats(255, {4{8'd1}}, {4{8'd1}});
    chk("t7_rdy_end", in_ready0, 1'b0);
    wait_out("t7_ovld");
    chk("t7_acc", acc0, {4{24'd255}});
    take_out();

    // Reset mid-job, then a clean job
    start_job(8'd5, 1'b0);
    beats(2, {4{8'd9}}, {4{8'd9}});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_acc", acc0, 96'd0);
    chk("t6_rst_ctl", {busy0, in_ready0, out_valid0, sat0}, 7'd0);
    rst_n = 1'b1;
    tick();
    start_job(8'd1, 1'b0);
    beats(1, {4{8'd3}}, {4{8'd4}});
    wait_out("t6_ovld");
    chk("t6_acc", acc0, {4{24'd12}});
    take_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
